// File: rtl/merge_arbiter_pkg.sv
// Shared definitions for the merge arbiter: default packet width and FSM state encoding.
package ddp_pkg;

    localparam int PW_DEF = 38;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/merge_arbiter_if.sv
// 4-phase handshake bundle between two requesters, the merge arbiter and the downstream B stage.
interface merge_arbiter_if #(
    parameter int PW = ddp_pkg::PW_DEF
) ();

    logic [PW-1:0] PACKET_IN_A;
    logic          Send_in_a;
    logic          Ack_out_a;
    logic [PW-1:0] PACKET_IN_B;
    logic          Send_in_b;
    logic          Ack_out_b;
    logic [PW-1:0] PACKET_OUT;
    logic          Send_out;
    logic          Ack_in;
    logic          GNT_B;

    // Arbiter side
    modport slave (
        input  PACKET_IN_A, Send_in_a, PACKET_IN_B, Send_in_b, Ack_in,
        output Ack_out_a, Ack_out_b, PACKET_OUT, Send_out, GNT_B
    );

    // Requesters plus downstream stage, as seen from the environment
    modport master (
        output PACKET_IN_A, Send_in_a, PACKET_IN_B, Send_in_b, Ack_in,
        input  Ack_out_a, Ack_out_b, PACKET_OUT, Send_out, GNT_B
    );

endinterface

// File: rtl/merge_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not granted last.
module rr_pick (
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic last_b_i,
    output logic gnt_b_o
);

    assign gnt_b_o = req_b_i & (~req_a_i | ~last_b_i);

endmodule

// File: rtl/merge_arbiter.sv
// Merges two 4-phase packet streams into one with round-robin arbitration.
// Optional per-requester completion counters are enabled by defining MERGE_STATS_EN.
module merge_arbiter
    import ddp_pkg::*;
#(
    parameter int PW = PW_DEF
`ifdef MERGE_STATS_EN
    , parameter int CW = 16
`endif
) (
    input  logic                  CP,
    input  logic                  MR,
    merge_arbiter_if.slave        bus
`ifdef MERGE_STATS_EN
    , output logic [CW-1:0]       CNT_A
    , output logic [CW-1:0]       CNT_B
`endif
);

    state_t        state_q, state_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic          send_q, send_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          gnt_b_q, gnt_b_d;
    logic          last_b_q, last_b_d;
    logic          pick_b;
    logic          win_send;

    rr_pick u_rr_pick (
        .req_a_i  (bus.Send_in_a),
        .req_b_i  (bus.Send_in_b),
        .last_b_i (last_b_q),
        .gnt_b_o  (pick_b)
    );

    assign win_send = gnt_b_q ? bus.Send_in_b : bus.Send_in_a;

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_q  <= ST_IDLE;
            pkt_q    <= '0;
            send_q   <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            // Last grant starts as B so the first contention goes to A
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            send_q   <= send_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= last_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        send_d   = send_q;
        ack_a_d  = ack_a_q;
        ack_b_d  = ack_b_q;
        gnt_b_d  = gnt_b_q;
        last_b_d = last_b_q;
        case (state_q)
            ST_IDLE: begin
                send_d  = 1'b0;
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                // A stale downstream acknowledge blocks any new grant
                if ((bus.Send_in_a || bus.Send_in_b) && !bus.Ack_in) begin
                    gnt_b_d = pick_b;
                    pkt_d   = pick_b ? bus.PACKET_IN_B : bus.PACKET_IN_A;
                    send_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Winner's request is not consulted here; an early drop still completes
                if (bus.Ack_in) begin
                    send_d  = 1'b0;
                    ack_a_d = ~gnt_b_q;
                    ack_b_d = gnt_b_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!win_send && !bus.Ack_in) begin
                    ack_a_d  = 1'b0;
                    ack_b_d  = 1'b0;
                    last_b_d = gnt_b_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.PACKET_OUT = pkt_q;
    assign bus.Send_out   = send_q;
    assign bus.Ack_out_a  = ack_a_q;
    assign bus.Ack_out_b  = ack_b_q;
    assign bus.GNT_B      = gnt_b_q;

`ifdef MERGE_STATS_EN
    logic [CW-1:0] cnt_a_q, cnt_a_d;
    logic [CW-1:0] cnt_b_q, cnt_b_d;
    logic          xfer_done;

    assign xfer_done = (state_q == ST_ACK) && (state_d == ST_IDLE);

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (xfer_done) begin
            if (gnt_b_q) cnt_b_d = cnt_b_q + 1'b1;
            else         cnt_a_d = cnt_a_q + 1'b1;
        end
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign CNT_A = cnt_a_q;
    assign CNT_B = cnt_b_q;
`endif

endmodule

// File: tb/tb_merge_arbiter.sv
// Directed self-checking bench for merge_arbiter.
module tb_merge_arbiter;

    localparam int PW = 38;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    merge_arbiter_if #(.PW(PW)) bus ();

`ifdef MERGE_STATS_EN
    logic [3:0] cnt_a, cnt_b;
    merge_arbiter #(.PW(PW), .CW(4)) dut (
        .CP    (clk),
        .MR    (rst),
        .bus   (bus),
        .CNT_A (cnt_a),
        .CNT_B (cnt_b)
    );
`else
    merge_arbiter #(.PW(PW)) dut (
        .CP  (clk),
        .MR  (rst),
        .bus (bus)
    );
`endif

    localparam logic [PW-1:0] PKT_A  = 38'h0_0000_1234;
    localparam logic [PW-1:0] PKT_B  = 38'h2A_BCDE_F012;
    localparam logic [PW-1:0] PKT_A2 = 38'h15_5555_AAAA;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests already raised; runs IDLE->REQ->ACK->IDLE with an immediate downstream partner
    task automatic run_xfer(input string tag, input logic exp_b, input logic [PW-1:0] exp_pkt);
        tick();
        chk({tag, "_send"}, 64'(bus.Send_out), 64'd1);
        chk({tag, "_gnt"},  64'(bus.GNT_B), 64'(exp_b));
        chk({tag, "_pkt"},  64'(bus.PACKET_OUT), 64'(exp_pkt));
        bus.Ack_in = 1'b1;
        tick();
        chk({tag, "_acka"}, 64'(bus.Ack_out_a), 64'(!exp_b));
        chk({tag, "_ackb"}, 64'(bus.Ack_out_b), 64'(exp_b));
        chk({tag, "_sdn"},  64'(bus.Send_out), 64'd0);
        if (exp_b) bus.Send_in_b = 1'b0;
        else       bus.Send_in_a = 1'b0;
        bus.Ack_in = 1'b0;
        tick();
        chk({tag, "_ackdn"}, 64'(bus.Ack_out_a | bus.Ack_out_b), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.Send_in_a = 1'b0;
        bus.Send_in_b = 1'b0;
        bus.Ack_in    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.PACKET_IN_A = '0;
        bus.PACKET_IN_B = '0;
        bus.Send_in_a   = 1'b0;
        bus.Send_in_b   = 1'b0;
        bus.Ack_in      = 1'b0;
        #3;
        chk("rst_send", 64'(bus.Send_out), 64'd0);
        chk("rst_pkt",  64'(bus.PACKET_OUT), 64'd0);
        chk("rst_gnt",  64'(bus.GNT_B), 64'd0);
        chk("rst_ack",  64'(bus.Ack_out_a | bus.Ack_out_b), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Lone A transfer
        bus.PACKET_IN_A = PKT_A;
        bus.Send_in_a   = 1'b1;
        run_xfer("solo_a", 1'b0, PKT_A);
        tick();
        chk("solo_idle", 64'(bus.Send_out), 64'd0);

        // Simultaneous requests right after reset alternate A,B,A,B
        do_reset();
        for (int r = 0; r < 4; r++) begin
            bus.PACKET_IN_A = PKT_A2;
            bus.PACKET_IN_B = PKT_B;
            bus.Send_in_a   = 1'b1;
            bus.Send_in_b   = 1'b1;
            run_xfer($sformatf("rr%0d", r), r[0], r[0] ? PKT_B : PKT_A2);
            bus.Send_in_a = 1'b0;
            bus.Send_in_b = 1'b0;
        end
`ifdef MERGE_STATS_EN
        chk("rr_cnt_a", 64'(cnt_a), 64'd2);
        chk("rr_cnt_b", 64'(cnt_b), 64'd2);
`endif

        // B arrives while A is in REQ; last grant is B so A wins solo
        bus.PACKET_IN_A = PKT_A;
        bus.Send_in_a   = 1'b1;
        tick();
        chk("pend_gnt_a", 64'(bus.GNT_B), 64'd0);
        bus.Send_in_b = 1'b1;
        bus.Ack_in    = 1'b1;
        tick();
        chk("pend_acka", 64'(bus.Ack_out_a), 64'd1);
        chk("pend_ackb", 64'(bus.Ack_out_b), 64'd0);
        chk("pend_pkt",  64'(bus.PACKET_OUT), 64'(PKT_A));
        bus.Send_in_a = 1'b0;
        bus.Ack_in    = 1'b0;
        tick();
        chk("pend_ackb2", 64'(bus.Ack_out_b), 64'd0);
        chk("pend_hold",  64'(bus.PACKET_OUT), 64'(PKT_A));
        run_xfer("pend_b", 1'b1, PKT_B);

        // Winner drops request early in REQ; transfer still completes
        bus.Send_in_a = 1'b1;
        tick();
        bus.Send_in_a = 1'b0;
        tick();
        chk("drop_send", 64'(bus.Send_out), 64'd1);
        bus.Ack_in = 1'b1;
        tick();
        chk("drop_acka", 64'(bus.Ack_out_a), 64'd1);
        bus.Ack_in = 1'b0;
        tick();
        chk("drop_done", 64'(bus.Ack_out_a), 64'd0);

        // Reset pulsed in ACK
        bus.PACKET_IN_A = PKT_A2;
        bus.Send_in_a   = 1'b1;
        tick();
        bus.Ack_in = 1'b1;
        tick();
        chk("mr_pre_ack", 64'(bus.Ack_out_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_ack",  64'(bus.Ack_out_a | bus.Ack_out_b), 64'd0);
        chk("mr_pkt",  64'(bus.PACKET_OUT), 64'd0);
        chk("mr_send", 64'(bus.Send_out), 64'd0);
        bus.Ack_in = 1'b0;
        tick();
        rst = 1'b0;
        run_xfer("mr_regrant", 1'b0, PKT_A2);

        // Downstream acknowledge stuck high in IDLE
        bus.Ack_in    = 1'b1;
        bus.Send_in_a = 1'b1;
        tick();
        chk("stuck_1", 64'(bus.Send_out), 64'd0);
        tick();
        chk("stuck_2", 64'(bus.Send_out), 64'd0);
        bus.Ack_in = 1'b0;
        run_xfer("stuck_rel", 1'b0, PKT_A2);

`ifdef MERGE_STATS_EN
        // Counter wrap with CW=4
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.Send_in_a = 1'b1;
            run_xfer($sformatf("wrap%0d", i), 1'b0, PKT_A2);
        end
        chk("wrap_cnt_a", 64'(cnt_a), 64'd1);
        chk("wrap_cnt_b", 64'(cnt_b), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/merge_arbiter.md
MERGE_ARBITER -- requirements
Module: merge_arbiter

Interface
REQ-001 Parameter: PW, 38, packet width in bits.
REQ-002 Parameter: CW, 16, grant-counter width in bits; used only with MERGE_STATS_EN.
REQ-003 Port: CP  input  1  clock; all state changes on rising edge.
REQ-004 Port: MR  input  1  reset; asynchronous, active-high.
REQ-005 Port: PACKET_IN_A  input  PW  packet from requester A; stable while Send_in_a is high.
REQ-006 Port: Send_in_a  input  1  requester A packet valid (4-phase request).
REQ-007 Port: Ack_out_a  output  1  4-phase acknowledge to requester A.
REQ-008 Port: PACKET_IN_B / Send_in_b / Ack_out_b  same widths and meanings for requester B.
REQ-009 Port: PACKET_OUT  output  PW  registered packet toward the B stage.
REQ-010 Port: Send_out  output  1  4-phase request to the B stage.
REQ-011 Port: Ack_in  input  1  4-phase acknowledge from the B stage.
REQ-012 Port: GNT_B  output  1  owner of the current transfer; 0 = A, 1 = B.
REQ-013 Port: CNT_A, CNT_B  output  CW  completed-transfer counts per requester; present only with MERGE_STATS_EN.

Function
REQ-014 FSM has states IDLE, REQ and ACK, encoded as shared-package constants.
REQ-015 IDLE: Send_out=0, Ack_out_a=0, Ack_out_b=0.
REQ-016 IDLE exit: at least one Send_in high and Ack_in low; winner selected, its packet latched into PACKET_OUT, GNT_B set, Send_out=1, go to REQ.
REQ-017 Latency: Send_out and PACKET_OUT valid exactly one CP edge after the edge sampling the winning Send_in.
REQ-018 Arbitration: single request wins outright; simultaneous requests go to the port not granted last (round-robin); first contention after reset goes to A.
REQ-019 REQ: Send_out and PACKET_OUT held; on Ack_in=1, Send_out<=0, winner Ack_out<=1, go to ACK.
REQ-020 ACK: winner Ack_out held 1; when winner Send_in=0 and Ack_in=0, Ack_out<=0, last-grant<=GNT_B, go to IDLE.
REQ-021 Loser request stays pending; no packet drop, no duplication, no Ack to the loser.
REQ-022 Winner dropping Send_in in REQ is a protocol error; transfer still completes unchanged.
REQ-023 Ack_in already high in IDLE blocks any grant until it falls.
REQ-024 PACKET_OUT changes only on IDLE->REQ; otherwise holds its value.
REQ-025 Only one of Ack_out_a and Ack_out_b is ever high.
REQ-026 Minimum full transfer with immediate partners: IDLE->REQ->ACK->IDLE in 3 edges; back-to-back alternation under continuous contention.

Reset
REQ-027 MR high forces IDLE, PACKET_OUT=0, Send_out=0, Ack_out_a=0, Ack_out_b=0, GNT_B=0, last-grant=B (so A wins first), CNT_A=CNT_B=0, independent of CP.
REQ-028 MR during REQ or ACK aborts the transfer with no Ack issued; a requester still high re-arbitrates from IDLE after MR falls.

Configuration
REQ-029 Macro MERGE_STATS_EN defined: CNT_A/CNT_B ports exist; the winner's counter increments by 1 on each ACK->IDLE transition and wraps from 2^CW-1 to 0.
REQ-030 Macro MERGE_STATS_EN undefined: the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-031 Shared package ddp_pkg holds the PW default, the FSM state constants and the 2-bit state type.
REQ-032 Sub-module rr_pick (combinational: two requests plus last-grant -> grant) is the single natural sub-block; FSM, packet register and counters stay in merge_arbiter.

Verification
REQ-033 A alone sends PACKET_IN_A=38'h0_0000_1234, Ack_in answers after 1 cycle -> PACKET_OUT=38'h0_0000_1234 one edge after request, GNT_B=0, Ack_out_a pulse, IDLE after 3 edges.
REQ-034 A and B raised in the same cycle, 4 times, right after reset -> grant order A,B,A,B; with MERGE_STATS_EN, CNT_A=2 and CNT_B=2.
REQ-035 B raised while A is in REQ -> Ack_out_b stays 0 and PACKET_OUT holds A's packet until A completes; B is then granted on the next IDLE edge.
REQ-036 MR pulsed while in ACK -> all outputs 0 immediately; a held Send_in_a is re-granted after MR falls.
REQ-037 Ack_in stuck high in IDLE with Send_in_a=1 -> Send_out stays 0 until Ack_in falls, then Send_out=1 on the next edge.
REQ-038 With CW=4 and MERGE_STATS_EN, 17 A transfers -> CNT_A wraps to 1.
